u_sequencer: RTL and testbench
==============================

Name: u_sequencer

Overview:
Microprogram sequencer for the MCU controller. It is the fetch side of the control ROM: it drives ADDR into u_program_memory and decodes the returned micro-instruction into a next-address decision and a set of control outputs. The ROM is purely combinational, so each instruction is addressed, decoded and executed in one clock. Sits between the datapath condition flags and the control ROM.

Parameters:
ADDR_W, 4, micro-address width; ROM depth is 2^ADDR_W.
NCOND, 4, number of condition inputs.
CSEL_W, 2, width of the condition-select field; must satisfy 2^CSEL_W >= NCOND.
CTRL_W, 4, width of the control field passed to the datapath.
START_ADDR, 0, entry micro-address loaded on START.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-high reset.
START  input  1  begin microprogram execution; sampled in IDLE and DONE only.
COND  input  NCOND  datapath condition flags, sampled on the clock edge.
UI  input  UI_W  micro-instruction from the ROM. Layout, MSB to LSB: {OP, CSEL, TGT, CTRL}. UI_W = OP_W+CSEL_W+ADDR_W+CTRL_W.
ADDR  output  ADDR_W  micro-address driven to the ROM (the uPC).
CTRL  output  CTRL_W  control word to the datapath.
BUSY  output  1  high while in RUN.
DONE  output  1  high in DONE state.

Behaviour:
- Reset (async): state=IDLE, uPC=0, ADDR=0, CTRL=0, BUSY=0, DONE=0, return register=0. Takes effect immediately, with no clock edge needed, from any state including mid-RUN.
- States: IDLE, RUN, DONE. BUSY and DONE are decoded from the state register.
- IDLE: CTRL=0. START=1 -> uPC<=START_ADDR, go to RUN.
- RUN: ADDR=uPC. CTRL=UI.CTRL combinationally, in the same cycle the instruction is addressed. START is ignored.
- Opcodes (OP_W=2):
  - 00 NEXT: uPC<=uPC+1.
  - 01 JMP: uPC<=TGT.
  - 10 BR: uPC<= COND[CSEL] ? TGT : uPC+1.
  - 11 END: go to DONE; uPC holds.
- Arithmetic: uPC+1 is modulo 2^ADDR_W, so address 2^ADDR_W-1 wraps to 0.
- BR with CSEL>=NCOND: condition reads as 0 (falls through).
- BR with TGT equal to the current uPC: wait loop. CTRL is re-asserted every cycle until the condition goes false.
- COND value is the one present at the edge that ends the instruction's cycle.
- END cycle: CTRL=UI.CTRL during that cycle; 0 from the next cycle on.
- DONE: BUSY=0, DONE=1, CTRL=0, ADDR holds the END address. START=1 -> uPC<=START_ADDR, go to RUN; DONE falls on that same edge. DONE persists until START or Reset.
- Latency: START edge -> first instruction executing in the next cycle. END -> DONE=1 on the following cycle.

Optional Feature:
USEQ_CALL_EN
- Defined: OP_W=3 and a 1-deep subroutine return register (ADDR_W bits).
  - 0xx opcodes behave as above.
  - 100 CALL: retreg<=uPC+1 (wrapped), uPC<=TGT.
  - 101 RET: uPC<=retreg.
  - 110 and 111: treated as NEXT.
  - A nested CALL overwrites retreg; no depth check is performed.
- Undefined: OP_W=2, no return register; only the four base opcodes exist.

Test Plan:
1. Reset, then a 1-cycle START. ROM: 0 NEXT ctrl=1, 1 NEXT ctrl=2, 2 END ctrl=3 -> ADDR 0,1,2 on consecutive cycles; CTRL 1,2,3; BUSY high for 3 cycles; DONE=1 on the 4th cycle with CTRL=0.
2. Wait loop: addr 1 = BR csel=2 tgt=1; COND[2] high for 3 edges then low -> ADDR=1 for 4 cycles, then ADDR=2.
3. JMP and wrap: addr 0 JMP tgt=15; addr 15 NEXT -> ADDR sequence 0,15,0.
4. Assert Reset between edges while ADDR=5 in RUN -> ADDR=0, BUSY=0, CTRL=0 immediately, with no clock edge; state is IDLE.
5. START held high during RUN has no effect on ADDR. From DONE, a START pulse -> ADDR=START_ADDR and DONE=0 on the next edge.
6. With USEQ_CALL_EN: addr 2 CALL tgt=8; addr 8 RET -> ADDR sequence 2,8,3.

Source files
------------

// File: rtl/u_sequencer.sv
// u_sequencer: microprogram sequencer fetching from a combinational control ROM.
// Optional CALL/RET with a 1-deep return register when USEQ_CALL_EN is defined.
module u_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int NCOND      = 4,
  parameter int CSEL_W     = 2,
  parameter int CTRL_W     = 4,
  parameter int START_ADDR = 0,
`ifdef USEQ_CALL_EN
  localparam int OP_W      = 3,
`else
  localparam int OP_W      = 2,
`endif
  localparam int UI_W      = OP_W + CSEL_W + ADDR_W + CTRL_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              START,
  input  logic [NCOND-1:0]  COND,
  input  logic [UI_W-1:0]   UI,
  output logic [ADDR_W-1:0] ADDR,
  output logic [CTRL_W-1:0] CTRL,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [OP_W-1:0] OP_NEXT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_END  = OP_W'(3);
`ifdef USEQ_CALL_EN
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(4);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(5);
`endif

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam int CSEL_N = 2 ** CSEL_W;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] upc_inc;
`ifdef USEQ_CALL_EN
  logic [ADDR_W-1:0] ret_q, ret_d;
`endif

  logic [OP_W-1:0]   op;
  logic [CSEL_W-1:0] csel;
  logic [ADDR_W-1:0] tgt;
  logic [CTRL_W-1:0] ctrl_f;
  logic [CSEL_N-1:0] cond_ext;
  logic              cond_hit;

  assign {op, csel, tgt, ctrl_f} = UI;
  assign upc_inc = upc_q + ADDR_W'(1);

  // Selects beyond the implemented flags read as zero.
  always_comb begin
    cond_ext = '0;
    for (int i = 0; i < NCOND; i++) begin
      cond_ext[i] = COND[i];
    end
  end

  assign cond_hit = cond_ext[csel];

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
`ifdef USEQ_CALL_EN
    ret_d   = ret_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          upc_d   = START_A;
        end
      end
      S_RUN: begin
        case (op)
          OP_NEXT: upc_d = upc_inc;
          OP_JMP:  upc_d = tgt;
          OP_BR:   upc_d = cond_hit ? tgt : upc_inc;
          OP_END:  state_d = S_DONE;
`ifdef USEQ_CALL_EN
          OP_CALL: begin
            ret_d = upc_inc;
            upc_d = tgt;
          end
          OP_RET:  upc_d = ret_q;
`endif
          default: upc_d = upc_inc;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

`ifdef USEQ_CALL_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ret_q <= '0;
    else       ret_q <= ret_d;
  end
`endif

  assign ADDR = upc_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);
  assign CTRL = BUSY ? ctrl_f : '0;

endmodule

// File: tb/tb_u_sequencer.sv
// tb_u_sequencer: directed program scenarios plus random ROMs/stimulus
// checked against a cycle-level behavioural model of the sequencer.
module tb_u_sequencer;

  localparam int ADDR_W = 4;
  localparam int NCOND  = 4;
  localparam int CSEL_W = 2;
  localparam int CTRL_W = 4;
  localparam int START_ADDR = 0;
`ifdef USEQ_CALL_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif
  localparam int UI_W = OP_W + CSEL_W + ADDR_W + CTRL_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              START;
  logic [NCOND-1:0]  COND;
  logic [UI_W-1:0]   UI;
  logic [ADDR_W-1:0] ADDR;
  logic [CTRL_W-1:0] CTRL;
  logic              BUSY;
  logic              DONE;

  logic [UI_W-1:0] rom [DEPTH];

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 run, 2 done
  int m_st;
  int m_pc;
  int m_ret;

  u_sequencer #(
    .ADDR_W(ADDR_W), .NCOND(NCOND), .CSEL_W(CSEL_W),
    .CTRL_W(CTRL_W), .START_ADDR(START_ADDR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .START(START), .COND(COND),
    .UI(UI), .ADDR(ADDR), .CTRL(CTRL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 Clk = ~Clk;

  assign UI = rom[ADDR];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [UI_W-1:0] enc(input int op, input int csel,
                                          input int tgt, input int ctrl);
    logic [OP_W-1:0]   o;
    logic [CSEL_W-1:0] c;
    logic [ADDR_W-1:0] t;
    logic [CTRL_W-1:0] k;
    o = OP_W'(op);
    c = CSEL_W'(csel);
    t = ADDR_W'(tgt);
    k = CTRL_W'(ctrl);
    return {o, c, t, k};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < DEPTH; i++) rom[i] = enc(3, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_st = 0;
    m_pc = 0;
    m_ret = 0;
  endtask

  task automatic model_step();
    logic [UI_W-1:0] w;
    int op, csel, tgt, nxt;
    w    = rom[m_pc];
    op   = int'(w[UI_W-1 -: OP_W]);
    csel = int'(w[CTRL_W+ADDR_W +: CSEL_W]);
    tgt  = int'(w[CTRL_W +: ADDR_W]);
    nxt  = (m_pc + 1) % DEPTH;
    if (m_st != 1) begin
      if (START) begin
        m_st = 1;
        m_pc = START_ADDR;
      end
    end else begin
      if (op == 0) m_pc = nxt;
      else if (op == 1) m_pc = tgt;
      else if (op == 2) m_pc = (csel < NCOND && COND[csel]) ? tgt : nxt;
      else if (op == 3) m_st = 2;
`ifdef USEQ_CALL_EN
      else if (op == 4) begin
        m_ret = nxt;
        m_pc = tgt;
      end
      else if (op == 5) m_pc = m_ret;
`endif
      else m_pc = nxt;
    end
  endtask

  task automatic cmp_model(input string tag);
    int exp_ctrl;
    exp_ctrl = (m_st == 1) ? int'(rom[m_pc][CTRL_W-1:0]) : 0;
    chk({tag, "_addr"}, 32'(ADDR), 32'(m_pc));
    chk({tag, "_ctrl"}, 32'(CTRL), 32'(exp_ctrl));
    chk({tag, "_busy"}, 32'(BUSY), 32'(m_st == 1));
    chk({tag, "_done"}, 32'(DONE), 32'(m_st == 2));
  endtask

  // One clock: inputs are already set; sample at the following negedge.
  task automatic step(input string tag);
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    model_reset();
    Reset = 1'b0;
    @(negedge Clk);
    cmp_model("rst");
  endtask

  initial begin
    Reset = 1'b1;
    START = 1'b0;
    COND  = '0;
    rom_clear();
    model_reset();
    #3;
    cmp_model("por");
    Reset = 1'b0;

    // 1: straight-line program
    rom_clear();
    rom[0] = enc(0, 0, 0, 1);
    rom[1] = enc(0, 0, 0, 2);
    rom[2] = enc(3, 0, 0, 3);
    do_reset();
    START = 1'b1;
    step("t1a");
    chk("t1_addr0", 32'(ADDR), 0);
    chk("t1_ctrl0", 32'(CTRL), 1);
    START = 1'b0;
    step("t1b");
    step("t1c");
    chk("t1_ctrl2", 32'(CTRL), 3);
    chk("t1_busy2", 32'(BUSY), 1);
    step("t1d");
    chk("t1_done", 32'(DONE), 1);
    chk("t1_ctrl_done", 32'(CTRL), 0);
    chk("t1_addr_hold", 32'(ADDR), 2);
    step("t1e");

    // 2: wait loop on COND[2]
    rom_clear();
    rom[0] = enc(0, 0, 0, 5);
    rom[1] = enc(2, 2, 1, 6);
    rom[2] = enc(3, 0, 0, 7);
    do_reset();
    START = 1'b1;
    step("t2s");
    START = 1'b0;
    COND = 4'b0100;
    step("t2a");
    for (int i = 0; i < 3; i++) begin
      step("t2w");
      chk("t2_wait_addr", 32'(ADDR), 1);
      chk("t2_wait_ctrl", 32'(CTRL), 6);
    end
    COND = 4'b1011;
    step("t2x");
    chk("t2_exit", 32'(ADDR), 2);
    COND = '0;

    // 3: JMP and wrap
    rom_clear();
    rom[0]  = enc(1, 0, 15, 9);
    rom[15] = enc(0, 0, 0, 4);
    do_reset();
    START = 1'b1;
    step("t3a");
    START = 1'b0;
    step("t3b");
    chk("t3_jmp", 32'(ADDR), 15);
    step("t3c");
    chk("t3_wrap", 32'(ADDR), 0);

    // 4: async reset mid-run at ADDR=5
    rom_clear();
    for (int i = 0; i < 8; i++) rom[i] = enc(0, 0, 0, i + 1);
    do_reset();
    START = 1'b1;
    step("t4s");
    START = 1'b0;
    for (int i = 0; i < 5; i++) step("t4r");
    chk("t4_at5", 32'(ADDR), 5);
    #2;
    Reset = 1'b1;
    #1;
    chk("t4_addr", 32'(ADDR), 0);
    chk("t4_busy", 32'(BUSY), 0);
    chk("t4_ctrl", 32'(CTRL), 0);
    chk("t4_done", 32'(DONE), 0);
    model_reset();
    @(posedge Clk);
    #1;
    chk("t4_idle", 32'(BUSY), 0);
    Reset = 1'b0;
    @(negedge Clk);
    cmp_model("t4");

    // 5: START held during RUN, restart from DONE
    rom_clear();
    rom[0] = enc(0, 0, 0, 1);
    rom[1] = enc(0, 0, 0, 2);
    rom[2] = enc(3, 0, 0, 3);
    START = 1'b1;
    step("t5a");
    step("t5b");
    chk("t5_held", 32'(ADDR), 1);
    step("t5c");
    START = 1'b0;
    step("t5d");
    step("t5e");
    chk("t5_persist", 32'(DONE), 1);
    START = 1'b1;
    step("t5f");
    chk("t5_restart", 32'(ADDR), START_ADDR);
    chk("t5_donefall", 32'(DONE), 0);
    START = 1'b0;

`ifdef USEQ_CALL_EN
    // 6: CALL / RET
    rom_clear();
    rom[0] = enc(0, 0, 0, 1);
    rom[1] = enc(0, 0, 0, 2);
    rom[2] = enc(4, 0, 8, 3);
    rom[8] = enc(5, 0, 0, 4);
    rom[3] = enc(6, 0, 0, 5);
    do_reset();
    START = 1'b1;
    step("t6s");
    START = 1'b0;
    step("t6a");
    step("t6b");
    chk("t6_call", 32'(ADDR), 2);
    step("t6c");
    chk("t6_tgt", 32'(ADDR), 8);
    step("t6d");
    chk("t6_ret", 32'(ADDR), 3);
    step("t6e");
    chk("t6_op6", 32'(ADDR), 4);
`endif

    // random programs and stimulus
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          rom[i] = enc(int'($urandom_range(0, 2 ** OP_W - 1)),
                       int'($urandom_range(0, 3)),
                       int'($urandom_range(0, DEPTH - 1)),
                       int'($urandom_range(0, 15)));
        end
      end
      START = ($urandom_range(0, 3) == 0);
      COND  = NCOND'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #1;
        Reset = 1'b1;
        #1;
        model_reset();
        cmp_model("rnd_rst");
        Reset = 1'b0;
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
